// File: rtl/spi_periph_pkg.sv
// Shared types and constants for the SPI peripheral master.
package spi_periph_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BITS_LAST = 7;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sck_div.sv
// Half-period tick generator for sck; restart_i clears the count.
module spi_sck_div #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_periph_master.sv
// SPI master/sequencer: one byte per command, MSB first, sck idle low.
// Define SPI_PERIPH_MASTER_RX_EN to capture miso into rsp_data.
module spi_periph_master
  import spi_periph_pkg::*;
#(
  parameter int NUM_SS      = 2,
  parameter int HALF_PERIOD = 2,
  parameter int SEL_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SEL_W-1:0]      cmd_sel,
  input  logic [SPI_BYTE_W-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [SPI_BYTE_W-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SS-1:0]     ss_n
);

  spi_state_e state_q, state_d;

  logic [SEL_W-1:0]      sel_q;
  logic                  err_q;
  logic [SPI_BYTE_W-1:0] tx_q;
  logic [2:0]            bit_q;
  logic                  done_q;
  logic                  rsp_err_q;
  logic                  tick;
  logic                  restart;
  logic                  accept;
  logic                  sel_bad;
  logic                  enter_high;
  logic                  enter_low;
  logic                  enter_done;

  assign accept  = cmd_valid && cmd_ready;
  assign sel_bad = ({1'b0, cmd_sel} >= (SEL_W+1)'(NUM_SS));

  assign restart    = (state_d != state_q);
  assign enter_high = restart && (state_d == HIGH);
  assign enter_low  = restart && (state_d == LOW);
  assign enter_done = restart && (state_d == DONE);

  spi_sck_div #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (tick) state_d = HIGH;
      HIGH:    if (tick) state_d = done_q ? HOLD : LOW;
      LOW:     if (tick) state_d = HIGH;
      HOLD:    if (tick) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    sck       = (state_q == HIGH);
    rsp_valid = (state_q == DONE);
    ss_n      = '1;
    if (!err_q && (state_q inside {SETUP, HIGH, LOW, HOLD})) begin
      for (int i = 0; i < NUM_SS; i++) begin
        if (sel_q == SEL_W'(i)) ss_n[i] = 1'b0;
      end
    end
  end

  // tx_q[7] is the live mosi bit; clearing it on DONE idles mosi low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      err_q     <= 1'b0;
      tx_q      <= '0;
      bit_q     <= '0;
      done_q    <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        sel_q  <= cmd_sel;
        err_q  <= sel_bad;
        tx_q   <= cmd_data;
        bit_q  <= '0;
        done_q <= 1'b0;
      end
      if (enter_high) begin
        if (bit_q == 3'(SPI_BITS_LAST)) done_q <= 1'b1;
        else                            bit_q  <= bit_q + 3'd1;
      end
      if (enter_low) tx_q <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
      if (enter_done) begin
        tx_q      <= '0;
        rsp_err_q <= err_q;
      end
    end
  end

  assign mosi    = tx_q[SPI_BYTE_W-1];
  assign rsp_err = rsp_err_q;

`ifdef SPI_PERIPH_MASTER_RX_EN
  logic [SPI_BYTE_W-1:0] rx_q;
  logic [SPI_BYTE_W-1:0] rsp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      if (enter_high) rx_q <= {rx_q[SPI_BYTE_W-2:0], miso};
      if (enter_done) rsp_data_q <= rx_q;
    end
  end

  assign rsp_data = rsp_data_q;
`else
  logic unused_miso;
  assign unused_miso = miso;
  assign rsp_data    = '0;
`endif

endmodule

// File: doc/spi_periph_master.md
Name: spi_periph_master

Overview:
SPI master and sequencer for the SPI peripheral modules (counter control/compare registers and similar shift-register slaves).
- Takes byte-write commands from the processor-side FSM over a valid/ready handshake.
- Selects one of NUM_SS active-low slave selects, generates sck, and shifts the byte MSB-first.
- Captures miso and returns a one-cycle response.

Parameters:
NUM_SS, 2, number of slave-select lines (ss_n[0] = ss1, ss_n[1] = ss2); range 1..8.
HALF_PERIOD, 2, clk cycles per sck half-period; minimum 1.
SEL_W, 3, width of cmd_sel; must satisfy 2^SEL_W >= NUM_SS.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block idle, can accept a command.
cmd_sel  in  SEL_W  target slave index.
cmd_data  in  8  byte to shift out, MSB first.
rsp_valid  out  1  one-cycle pulse: transfer complete.
rsp_data  out  8  byte captured from miso; held until the next rsp_valid.
rsp_err  out  1  qualified by rsp_valid: cmd_sel >= NUM_SS.
sck  out  1  SPI clock, idle low.
mosi  out  1  serial data out.
miso  in  1  serial data in.
ss_n  out  NUM_SS  slave selects, active low.

Behaviour:
- Reset (async assert, sync release) is valid at any time, including mid-transfer. Reset values:
  - state=IDLE, cmd_ready=1, sck=0, mosi=0, ss_n=all 1.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - Bit counter and divider counter = 0.
- Handshake:
  - Accept when cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE; it drops the cycle after acceptance.
  - cmd_valid while busy is ignored; the requester holds it.
- States: IDLE -> SETUP -> HIGH <-> LOW -> HOLD -> DONE -> IDLE.
  - IDLE: on accept, latch sel/data and drive mosi=data[7]. If sel < NUM_SS, drive ss_n[sel]=0; otherwise keep all ss_n high and set the err flag. Go to SETUP.
  - SETUP: sck=0 for HALF_PERIOD cycles, then go to HIGH.
  - HIGH: sck=1 for HALF_PERIOD cycles.
    - On the entry cycle, sample miso into shift_in[0] after shifting left.
    - On exit: if 8 bits have been sent, go to HOLD; otherwise go to LOW.
  - LOW: sck=0; on entry, drive mosi to the next bit. Stay HALF_PERIOD cycles, then go to HIGH.
  - HOLD: sck=0 and ss_n still asserted for HALF_PERIOD cycles.
  - DONE (1 cycle): ss_n all 1, mosi=0, rsp_valid=1, rsp_data=captured byte, rsp_err=err flag. Go to IDLE.
- Timing:
  - ss_n is low for exactly 17*HALF_PERIOD cycles.
  - Exactly 8 sck rising edges occur per transfer.
  - mosi is stable >= HALF_PERIOD cycles around each rising edge.
  - Accept-to-rsp_valid latency = 17*HALF_PERIOD+1 cycles.
  - Back-to-back: a new command can be accepted the cycle after DONE.
- Invalid sel: full timing is kept with no select asserted and sck still toggling. rsp_data = captured miso; rsp_err=1.
- Divider wraps to 0 on every state change. Bit counter is 3-bit plus a done flag; no wrap beyond 8 bits.

Optional Feature:
SPI_PERIPH_MASTER_RX_EN
- Defined: miso is captured as described.
- Undefined: no miso sampling logic; rsp_data is constant 0; miso is unused.

Decomposition:
- Shared package spi_periph_pkg:
  - state enum (IDLE, SETUP, HIGH, LOW, HOLD, DONE);
  - constant SPI_BYTE_W=8;
  - constant SPI_BITS_LAST=7.
- One natural sub-module: spi_sck_div, the HALF_PERIOD tick generator with a restart input.

Test Plan:
- Reset idle: check the reset values listed under Behaviour; toggle cmd_valid=0 for 10 cycles -> outputs unchanged.
- Write 0xA5 to sel=0, HALF_PERIOD=2:
  - ss_n=2'b10 for 34 cycles with 8 sck pulses;
  - slave model captures 0xA5;
  - rsp_valid at accept+35; rsp_err=0.
- miso slave model returns 0x3C on sel=1 -> rsp_data=0x3C (RX_EN defined); rsp_data=0x00 with RX_EN undefined.
- sel=5 with NUM_SS=2 -> ss_n stays 2'b11 throughout, 8 sck pulses, rsp_err=1.
- Back-to-back commands with cmd_valid held high:
  - cmd_ready=0 throughout the busy period; second accept on the cycle after rsp_valid;
  - two distinct responses.
- rst_n asserted at the 4th sck high -> same cycle: ss_n=all 1, sck=0, cmd_ready=1; no rsp_valid; next command runs normally.
